controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
- REQ-001 SHALL have parameter GRID_DIM, default 256, lattice cell count; last cell index is GRID_DIM-1.
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath word width; no port of this block depends on it.
- REQ-003 SHALL have Clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have Reset, input, 1: asynchronous, active-high reset.
- REQ-005 SHALL have count_init, input, 8: current cell index from the external counter; wraps from 255 to 0.
- REQ-006 SHALL have div_valid, input, 1: the divider's quotients are ready.
- REQ-007 SHALL have LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL, inputs, 1 each: boundary flags of the current cell.
- REQ-008 SHALL have WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem, outputs, 1 each: memory write enables.
- REQ-009 SHALL have select_p_mem, select_ux_mem, select_uy_mem, select_fin_mem, outputs, 1 each: memory write-data source (0 = initial value, 1 = computed or streamed value).
- REQ-010 SHALL have select_ux_reg, output, 2: ux register source (00 = divider, 01 = lid velocity, 10 = zero).
- REQ-011 SHALL have select_p_reg and select_uy_reg, outputs, 1 each: register source (0 = computed, 1 = boundary value, where boundary uy is zero).
- REQ-012 SHALL have count_init_en, output, 1: advances the external cell counter.
- REQ-013 SHALL have div_start, output, 1: a one-cycle divider start pulse.
- REQ-014 SHALL have the register-load outputs LD_EN_P, LD_EN_PUX, LD_EN_PUY, LD_EN_UX, LD_EN_UY, LD_EN_FEQ0..LD_EN_FEQ8 and LD_EN_FOUT0..LD_EN_FOUT8, 1 bit each.

Function
- REQ-015 SHALL be an FSM with states IDLE, INIT, RHO, DIV_START, DIV_WAIT, BC, FEQ, COLLIDE, WRITE, STREAM; any output not named for a state SHALL be 0 in that state.
- REQ-016 IDLE: all outputs 0; next state INIT unconditionally.
- REQ-017 INIT: count_init_en, WE_p_mem, WE_ux_mem, WE_uy_mem and WE_fin_mem are 1, and all select_*_mem are 0; stays in INIT until count_init == GRID_DIM-1, then goes to RHO.
- REQ-018 RHO: LD_EN_P, LD_EN_PUX and LD_EN_PUY are 1, select_p_reg is 0; next state DIV_START.
- REQ-019 DIV_START: div_start is 1 for exactly one cycle; next state DIV_WAIT.
- REQ-020 DIV_WAIT: outputs 0 while div_valid is 0; in the cycle div_valid is 1, LD_EN_UX and LD_EN_UY are 1 with select_ux_reg = 00 and select_uy_reg = 0, and the next state is BC; div_valid is ignored in all other states.
- REQ-021 BC when LID is 1 (LID has priority over the wall flags): select_ux_reg = 01, select_uy_reg = 1, select_p_reg = 1, and LD_EN_UX, LD_EN_UY and LD_EN_P are 1.
- REQ-022 BC when LID is 0 and any wall flag is 1: select_ux_reg = 10, select_uy_reg = 1, select_p_reg = 1, and LD_EN_UX, LD_EN_UY and LD_EN_P are 1.
- REQ-023 BC when no flag is set: no loads; in every case the next state is FEQ.
- REQ-024 FEQ: LD_EN_FEQ0..8 are all 1 for one cycle; next state COLLIDE.
- REQ-025 COLLIDE: LD_EN_FOUT0..8 are all 1 for one cycle; next state WRITE.
- REQ-026 WRITE: WE_p_mem, WE_ux_mem, WE_uy_mem, WE_feq_mem, WE_fout_mem and count_init_en are 1, and select_p_mem, select_ux_mem and select_uy_mem are 1; next state STREAM if count_init == GRID_DIM-1, else RHO.
- REQ-027 STREAM: WE_fin_mem, select_fin_mem and count_init_en are 1; stays until count_init == GRID_DIM-1, then goes to RHO (next time step, repeating forever).
- REQ-028 Outputs SHALL be combinational decode of the state, plus div_valid in DIV_WAIT and the boundary flags in BC; the state register is the only storage.
- REQ-029 Cell compute latency without divider wait SHALL be 7 cycles, RHO through WRITE.

Reset
- REQ-030 Reset = 1 SHALL force state IDLE asynchronously, with all outputs 0, including when asserted mid-operation.
- REQ-031 After Reset is released, the first rising edge SHALL enter INIT.

Verification
- REQ-032 Reset, then release with count_init = 0 -> IDLE for one cycle, then INIT with count_init_en = 1 and WE_fin_mem = 1; INIT held until count_init = 255, then RHO.
- REQ-033 From RHO with div_valid held 0 for 5 cycles, then 1 -> div_start high exactly one cycle, LD_EN_UX = 1 only in the div_valid cycle, then BC.
- REQ-034 BC with LID = 1 and LEFT_WALL = 1 -> select_ux_reg = 01 and LD_EN_P = 1; with only BOTTOM_WALL = 1 -> select_ux_reg = 10; with no flags -> no loads.
- REQ-035 WRITE with count_init = 100 -> next state RHO; with count_init = 255 -> next state STREAM, where WE_fin_mem = 1 and select_fin_mem = 1.
- REQ-036 Reset asserted during COLLIDE -> all LD_EN_FOUT* outputs drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/controller.sv
// Lattice-Boltzmann cell controller: initialises the lattice, walks each cell through
// density, divide, boundary, equilibrium, collision and write-back, then streams.
module controller #(
  parameter int GRID_DIM   = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] count_init,
  input  logic       div_valid,
  input  logic       LID,
  input  logic       BOTTOM_WALL,
  input  logic       LEFT_WALL,
  input  logic       RIGHT_WALL,
  output logic       WE_p_mem,
  output logic       WE_ux_mem,
  output logic       WE_uy_mem,
  output logic       WE_fin_mem,
  output logic       WE_fout_mem,
  output logic       WE_feq_mem,
  output logic       select_p_mem,
  output logic       select_ux_mem,
  output logic       select_uy_mem,
  output logic       select_fin_mem,
  output logic [1:0] select_ux_reg,
  output logic       select_p_reg,
  output logic       select_uy_reg,
  output logic       count_init_en,
  output logic       div_start,
  output logic       LD_EN_P,
  output logic       LD_EN_PUX,
  output logic       LD_EN_PUY,
  output logic       LD_EN_UX,
  output logic       LD_EN_UY,
  output logic       LD_EN_FEQ0, LD_EN_FEQ1, LD_EN_FEQ2, LD_EN_FEQ3, LD_EN_FEQ4,
  output logic       LD_EN_FEQ5, LD_EN_FEQ6, LD_EN_FEQ7, LD_EN_FEQ8,
  output logic       LD_EN_FOUT0, LD_EN_FOUT1, LD_EN_FOUT2, LD_EN_FOUT3, LD_EN_FOUT4,
  output logic       LD_EN_FOUT5, LD_EN_FOUT6, LD_EN_FOUT7, LD_EN_FOUT8
);

  localparam logic [7:0] LAST_CELL = 8'(GRID_DIM - 1);

  // The cell index arrives on an 8-bit counter, so the lattice cannot exceed 256 cells.
  if (GRID_DIM < 1 || GRID_DIM > 256 || DATA_WIDTH < 1) begin : g_param_check
    $error("controller: GRID_DIM must be 1..256 and DATA_WIDTH positive");
  end

  typedef enum logic [3:0] {
    IDLE, INIT, RHO, DIV_START, DIV_WAIT, BC, FEQ, COLLIDE, WRITE, STREAM
  } state_t;

  state_t state;
  logic   last_cell;
  logic   any_wall;
  logic [8:0] ld_feq;
  logic [8:0] ld_fout;

  assign last_cell = (count_init == LAST_CELL);
  assign any_wall  = BOTTOM_WALL | LEFT_WALL | RIGHT_WALL;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      state <= INIT;
        INIT:      if (last_cell) state <= RHO;
        RHO:       state <= DIV_START;
        DIV_START: state <= DIV_WAIT;
        DIV_WAIT:  if (div_valid) state <= BC;
        BC:        state <= FEQ;
        FEQ:       state <= COLLIDE;
        COLLIDE:   state <= WRITE;
        WRITE:     state <= last_cell ? STREAM : RHO;
        STREAM:    if (last_cell) state <= RHO;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state directly so an asynchronous reset clears them at once.
  always_comb begin
    WE_p_mem       = 1'b0;
    WE_ux_mem      = 1'b0;
    WE_uy_mem      = 1'b0;
    WE_fin_mem     = 1'b0;
    WE_fout_mem    = 1'b0;
    WE_feq_mem     = 1'b0;
    select_p_mem   = 1'b0;
    select_ux_mem  = 1'b0;
    select_uy_mem  = 1'b0;
    select_fin_mem = 1'b0;
    select_ux_reg  = 2'b00;
    select_p_reg   = 1'b0;
    select_uy_reg  = 1'b0;
    count_init_en  = 1'b0;
    div_start      = 1'b0;
    LD_EN_P        = 1'b0;
    LD_EN_PUX      = 1'b0;
    LD_EN_PUY      = 1'b0;
    LD_EN_UX       = 1'b0;
    LD_EN_UY       = 1'b0;
    ld_feq         = '0;
    ld_fout        = '0;
    case (state)
      INIT: begin
        count_init_en = 1'b1;
        WE_p_mem      = 1'b1;
        WE_ux_mem     = 1'b1;
        WE_uy_mem     = 1'b1;
        WE_fin_mem    = 1'b1;
      end
      RHO: begin
        LD_EN_P   = 1'b1;
        LD_EN_PUX = 1'b1;
        LD_EN_PUY = 1'b1;
      end
      DIV_START: div_start = 1'b1;
      DIV_WAIT: begin
        LD_EN_UX = div_valid;
        LD_EN_UY = div_valid;
      end
      BC: begin
        if (LID || any_wall) begin
          select_ux_reg = LID ? 2'b01 : 2'b10;
          select_uy_reg = 1'b1;
          select_p_reg  = 1'b1;
          LD_EN_UX      = 1'b1;
          LD_EN_UY      = 1'b1;
          LD_EN_P       = 1'b1;
        end
      end
      FEQ:     ld_feq  = '1;
      COLLIDE: ld_fout = '1;
      WRITE: begin
        WE_p_mem      = 1'b1;
        WE_ux_mem     = 1'b1;
        WE_uy_mem     = 1'b1;
        WE_feq_mem    = 1'b1;
        WE_fout_mem   = 1'b1;
        count_init_en = 1'b1;
        select_p_mem  = 1'b1;
        select_ux_mem = 1'b1;
        select_uy_mem = 1'b1;
      end
      STREAM: begin
        WE_fin_mem     = 1'b1;
        select_fin_mem = 1'b1;
        count_init_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign {LD_EN_FEQ8, LD_EN_FEQ7, LD_EN_FEQ6, LD_EN_FEQ5, LD_EN_FEQ4,
          LD_EN_FEQ3, LD_EN_FEQ2, LD_EN_FEQ1, LD_EN_FEQ0} = ld_feq;
  assign {LD_EN_FOUT8, LD_EN_FOUT7, LD_EN_FOUT6, LD_EN_FOUT5, LD_EN_FOUT4,
          LD_EN_FOUT3, LD_EN_FOUT2, LD_EN_FOUT1, LD_EN_FOUT0} = ld_fout;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: cycle-by-cycle expected trace built from per-cell transaction scripts.
module tb_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] count_init = 8'd0;
  logic       div_valid = 1'b0;
  logic       LID = 1'b0, BOTTOM_WALL = 1'b0, LEFT_WALL = 1'b0, RIGHT_WALL = 1'b0;
  logic WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem;
  logic select_p_mem, select_ux_mem, select_uy_mem, select_fin_mem;
  logic [1:0] select_ux_reg;
  logic select_p_reg, select_uy_reg, count_init_en, div_start;
  logic LD_EN_P, LD_EN_PUX, LD_EN_PUY, LD_EN_UX, LD_EN_UY;
  logic LD_EN_FEQ0, LD_EN_FEQ1, LD_EN_FEQ2, LD_EN_FEQ3, LD_EN_FEQ4;
  logic LD_EN_FEQ5, LD_EN_FEQ6, LD_EN_FEQ7, LD_EN_FEQ8;
  logic LD_EN_FOUT0, LD_EN_FOUT1, LD_EN_FOUT2, LD_EN_FOUT3, LD_EN_FOUT4;
  logic LD_EN_FOUT5, LD_EN_FOUT6, LD_EN_FOUT7, LD_EN_FOUT8;

  controller #(.GRID_DIM(256), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .count_init(count_init), .div_valid(div_valid),
    .LID(LID), .BOTTOM_WALL(BOTTOM_WALL), .LEFT_WALL(LEFT_WALL), .RIGHT_WALL(RIGHT_WALL),
    .WE_p_mem(WE_p_mem), .WE_ux_mem(WE_ux_mem), .WE_uy_mem(WE_uy_mem),
    .WE_fin_mem(WE_fin_mem), .WE_fout_mem(WE_fout_mem), .WE_feq_mem(WE_feq_mem),
    .select_p_mem(select_p_mem), .select_ux_mem(select_ux_mem),
    .select_uy_mem(select_uy_mem), .select_fin_mem(select_fin_mem),
    .select_ux_reg(select_ux_reg), .select_p_reg(select_p_reg), .select_uy_reg(select_uy_reg),
    .count_init_en(count_init_en), .div_start(div_start),
    .LD_EN_P(LD_EN_P), .LD_EN_PUX(LD_EN_PUX), .LD_EN_PUY(LD_EN_PUY),
    .LD_EN_UX(LD_EN_UX), .LD_EN_UY(LD_EN_UY),
    .LD_EN_FEQ0(LD_EN_FEQ0), .LD_EN_FEQ1(LD_EN_FEQ1), .LD_EN_FEQ2(LD_EN_FEQ2),
    .LD_EN_FEQ3(LD_EN_FEQ3), .LD_EN_FEQ4(LD_EN_FEQ4), .LD_EN_FEQ5(LD_EN_FEQ5),
    .LD_EN_FEQ6(LD_EN_FEQ6), .LD_EN_FEQ7(LD_EN_FEQ7), .LD_EN_FEQ8(LD_EN_FEQ8),
    .LD_EN_FOUT0(LD_EN_FOUT0), .LD_EN_FOUT1(LD_EN_FOUT1), .LD_EN_FOUT2(LD_EN_FOUT2),
    .LD_EN_FOUT3(LD_EN_FOUT3), .LD_EN_FOUT4(LD_EN_FOUT4), .LD_EN_FOUT5(LD_EN_FOUT5),
    .LD_EN_FOUT6(LD_EN_FOUT6), .LD_EN_FOUT7(LD_EN_FOUT7), .LD_EN_FOUT8(LD_EN_FOUT8)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic we_p, we_ux, we_uy, we_fin, we_fout, we_feq;
    logic sel_p_mem, sel_ux_mem, sel_uy_mem, sel_fin_mem;
    logic [1:0] sel_ux_reg;
    logic sel_p_reg, sel_uy_reg, cnt_en, div_start;
    logic ld_p, ld_pux, ld_puy, ld_ux, ld_uy;
    logic [8:0] ld_feq;
    logic [8:0] ld_fout;
  } out_t;

  typedef struct {
    string      ph;
    logic       dv;
    logic [3:0] fl;   // {LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL}
    int         cnt;  // counter value forced before this cycle, -1 = keep counting
  } step_t;

  out_t  obs;
  step_t sched[$];
  int    total = 0;
  int    bad = 0;

  assign obs = {WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem,
                select_p_mem, select_ux_mem, select_uy_mem, select_fin_mem,
                select_ux_reg, select_p_reg, select_uy_reg, count_init_en, div_start,
                LD_EN_P, LD_EN_PUX, LD_EN_PUY, LD_EN_UX, LD_EN_UY,
                LD_EN_FEQ8, LD_EN_FEQ7, LD_EN_FEQ6, LD_EN_FEQ5, LD_EN_FEQ4,
                LD_EN_FEQ3, LD_EN_FEQ2, LD_EN_FEQ1, LD_EN_FEQ0,
                LD_EN_FOUT8, LD_EN_FOUT7, LD_EN_FOUT6, LD_EN_FOUT5, LD_EN_FOUT4,
                LD_EN_FOUT3, LD_EN_FOUT2, LD_EN_FOUT1, LD_EN_FOUT0};

  // Output table of each phase of the cell procedure.
  function automatic out_t model(string ph, logic dv, logic [3:0] fl);
    out_t e = '0;
    case (ph)
      "INIT":      begin e.cnt_en = 1; e.we_p = 1; e.we_ux = 1; e.we_uy = 1; e.we_fin = 1; end
      "RHO":       begin e.ld_p = 1; e.ld_pux = 1; e.ld_puy = 1; end
      "DIV_START": e.div_start = 1;
      "DIV_WAIT":  begin e.ld_ux = dv; e.ld_uy = dv; end
      "BC": if (fl != 4'b0000) begin
        e.sel_ux_reg = fl[3] ? 2'b01 : 2'b10;
        e.sel_uy_reg = 1; e.sel_p_reg = 1;
        e.ld_ux = 1; e.ld_uy = 1; e.ld_p = 1;
      end
      "FEQ":       e.ld_feq = '1;
      "COLLIDE":   e.ld_fout = '1;
      "WRITE": begin
        e.we_p = 1; e.we_ux = 1; e.we_uy = 1; e.we_feq = 1; e.we_fout = 1; e.cnt_en = 1;
        e.sel_p_mem = 1; e.sel_ux_mem = 1; e.sel_uy_mem = 1;
      end
      "STREAM":    begin e.we_fin = 1; e.sel_fin_mem = 1; e.cnt_en = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Inputs a phase does not look at get random noise.
  function automatic void add(string ph, logic dv, logic [3:0] fl, int cnt);
    step_t s;
    s.ph = ph; s.cnt = cnt;
    s.dv = (ph == "DIV_WAIT") ? dv : 1'($urandom);
    s.fl = (ph == "BC") ? fl : 4'($urandom);
    sched.push_back(s);
  endfunction

  function automatic void add_cell(int waits, logic [3:0] fl, int cnt);
    add("RHO", 0, 0, cnt);
    add("DIV_START", 0, 0, -1);
    for (int i = 0; i < waits; i++) add("DIV_WAIT", 0, 0, -1);
    add("DIV_WAIT", 1, 0, -1);
    add("BC", 0, fl, -1);
    add("FEQ", 0, 0, -1);
    add("COLLIDE", 0, 0, -1);
    add("WRITE", 0, 0, -1);
  endfunction

  // Entered at a falling edge; applies one cycle's inputs and yields its expectation.
  task automatic drive(input step_t s, output out_t e);
    if (s.cnt >= 0) count_init = 8'(s.cnt);
    div_valid = s.dv;
    {LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL} = s.fl;
    #1;
    e = model(s.ph, s.dv, s.fl);
  endtask

  // The bench plays the external cell counter.
  task automatic advance(input logic en);
    @(posedge Clk);
    #1;
    if (en) count_init = count_init + 8'd1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      div_valid = 1'($urandom);
      {LID, BOTTOM_WALL, LEFT_WALL, RIGHT_WALL} = 4'($urandom);
      #1;
      total++;
      if (obs !== '0) begin
        bad++; $display("FAIL reset_hold[%0d]: got %h expected 0", i, obs);
      end
      @(negedge Clk);
    end
    count_init = 8'd0;
    Reset = 1'b0;
  endtask

  task automatic test_init();
    out_t e;
    sched.delete();
    add("IDLE", 0, 0, 0);
    for (int i = 0; i < 256; i++) add("INIT", 0, 0, -1);
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL init[%0d] %s: got %h expected %h", i, sched[i].ph, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  task automatic test_div_handshake();
    out_t e;
    sched.delete();
    add_cell(5, 4'($urandom), -1);
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL div_wait[%0d] %s: got %h expected %h", i, sched[i].ph, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  task automatic test_boundary();
    out_t e;
    logic [3:0] flags [5] = '{4'b1010, 4'b0100, 4'b0000, 4'b0001, 4'b1111};
    sched.delete();
    foreach (flags[k]) add_cell(int'($urandom_range(0, 3)), flags[k], int'($urandom_range(0, 200)));
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL boundary[%0d] %s fl=%b: got %h expected %h", i, sched[i].ph, sched[i].fl, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  task automatic test_write_stream();
    out_t e;
    sched.delete();
    add_cell(0, 4'b0000, 100);
    add_cell(1, 4'b1000, 255);
    for (int i = 0; i < 256; i++) add("STREAM", 0, 0, -1);
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL write_stream[%0d] %s cnt=%0d: got %h expected %h", i, sched[i].ph, count_init, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  task automatic test_back_to_back();
    out_t e;
    sched.delete();
    for (int c = 0; c < 20; c++)
      add_cell(int'($urandom_range(0, 4)), 4'($urandom), int'($urandom_range(0, 254)));
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL back_to_back[%0d] %s: got %h expected %h", i, sched[i].ph, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  task automatic test_reset_mid();
    out_t e;
    sched.delete();
    add_cell(2, 4'b0010, 50);
    void'(sched.pop_back());  // stop at COLLIDE
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid_pre[%0d] %s: got %h expected %h", i, sched[i].ph, obs, e); end
      if (sched[i].ph != "COLLIDE") advance(e.cnt_en);
    end
    #2 Reset = 1'b1;
    #1;
    total++;
    if (obs.ld_fout !== 9'h000 || obs !== '0) begin
      bad++; $display("FAIL reset_async: got %h expected 0", obs);
    end
    @(posedge Clk);
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_after_edge: got %h expected 0", obs); end
    @(negedge Clk);
    Reset = 1'b0;
    sched.delete();
    add("IDLE", 0, 0, 0);
    for (int i = 0; i < 4; i++) add("INIT", 0, 0, -1);
    foreach (sched[i]) begin
      drive(sched[i], e);
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_restart[%0d] %s: got %h expected %h", i, sched[i].ph, obs, e); end
      advance(e.cnt_en);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_div_handshake();
    test_boundary();
    test_write_stream();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
